// File: rtl/qracc_pkg.sv
// qracc_pkg: shared constants and fill-state encoding for the window assembler.
//   QRACC_ROW_WIDTH    - default bits per activation-buffer row
//   QRACC_MAX_FILTER_Y - default maximum rows per window
//   QRACC_FSY_W        - width of the filter-size / row-count fields
//   qracc_fill_state_e - fill state machine states (FILL, HELD)
package qracc_pkg;

  localparam int unsigned QRACC_ROW_WIDTH    = 128;
  localparam int unsigned QRACC_MAX_FILTER_Y = 8;
  localparam int unsigned QRACC_FSY_W        = 4;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HELD = 1'b1
  } qracc_fill_state_e;

endpackage

// File: rtl/qracc_window_assembler_if.sv
// qracc_window_assembler_if: row-in / window-out handshake bundle.
//   row_valid_i, row_ready_o, row_data_i, row_last_i   - activation row channel
//   window_valid_o, window_ready_i, window_o,
//   window_rows_o                                      - assembled window channel
//   err_o                                              - sticky framing error
// Modports: master = the assembler, slave = row producer / window consumer.
interface qracc_window_assembler_if #(
  parameter int unsigned rowWidth   = qracc_pkg::QRACC_ROW_WIDTH,
  parameter int unsigned maxFilterY = qracc_pkg::QRACC_MAX_FILTER_Y
);

  logic                           row_valid_i;
  logic                           row_ready_o;
  logic [rowWidth-1:0]            row_data_i;
  logic                           row_last_i;
  logic                           window_valid_o;
  logic                           window_ready_i;
  logic [rowWidth*maxFilterY-1:0] window_o;
  logic [3:0]                     window_rows_o;
  logic                           err_o;

  modport master (
    input  row_valid_i, row_data_i, row_last_i, window_ready_i,
    output row_ready_o, window_valid_o, window_o, window_rows_o, err_o
  );

  modport slave (
    output row_valid_i, row_data_i, row_last_i, window_ready_i,
    input  row_ready_o, window_valid_o, window_o, window_rows_o, err_o
  );

endinterface

// File: rtl/qracc_window_assembler.sv
// qracc_window_assembler: collects activation rows into a window of up to
// maxFilterY rows using a fill bank and an output bank, so a new window can be
// filled while the previous one waits for the consumer.
// Ports:
//   clk             - single clock, rising edge
//   rst             - synchronous active-high reset
//   clear_i         - synchronous soft clear (csr_main_clear), drops any window
//   filter_size_y_i - expected rows per window (0 means maxFilterY)
//   bus             - qracc_window_assembler_if.master (row in, window out, err)
// Optional feature: QRACC_WINDOW_ERR_CHECK_EN enables the sticky framing error;
// without it err_o is tied low and the datapath is unchanged.
module qracc_window_assembler #(
  parameter int unsigned rowWidth   = qracc_pkg::QRACC_ROW_WIDTH,
  parameter int unsigned maxFilterY = qracc_pkg::QRACC_MAX_FILTER_Y
) (
  input logic                      clk,
  input logic                      rst,
  input logic                      clear_i,
  input logic [3:0]                filter_size_y_i,
  qracc_window_assembler_if.master bus
);

  import qracc_pkg::*;

  localparam int unsigned WIN_W = rowWidth * maxFilterY;
  localparam int unsigned CNT_W = $clog2(maxFilterY + 1);

  localparam logic [0:0] ST_FILL = 1'(FILL);
  localparam logic [0:0] ST_HELD = 1'(HELD);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIN_W-1:0] fill_q, fill_wr;
  logic [WIN_W-1:0] win_q, win_d, win_masked;
  logic             win_valid_q, win_valid_d;
  logic [3:0]       rows_q, rows_d;
  logic             row_ready_q, row_ready_d;

  logic             row_acc, win_acc, overflow, close, out_free, xfer;
  logic [CNT_W-1:0] cnt_inc, cnt_close, xfer_cnt;

  // Handshakes and the fill bank as it looks with this cycle's row written in.
  always_comb begin
    row_acc   = bus.row_valid_i && row_ready_q;
    win_acc   = win_valid_q && bus.window_ready_i;
    overflow  = row_acc && (cnt_q == CNT_W'(maxFilterY));
    close     = row_acc && (bus.row_last_i || overflow);
    out_free  = !win_valid_q || bus.window_ready_i;
    cnt_inc   = cnt_q + CNT_W'(1);
    // An overflowing row is discarded, so the window keeps its current count.
    cnt_close = overflow ? cnt_q : cnt_inc;
    fill_wr   = fill_q;
    for (int unsigned k = 0; k < maxFilterY; k++) begin
      if (row_acc && !overflow && (cnt_q == CNT_W'(k))) begin
        fill_wr[k*rowWidth +: rowWidth] = bus.row_data_i;
      end
    end
  end

  // Fill state machine: next state, transfer decision and output-bank update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_d       = win_q;
    win_valid_d = win_valid_q && !win_acc;
    rows_d      = rows_q;
    xfer        = 1'b0;
    xfer_cnt    = cnt_q;
    win_masked  = fill_wr;

    case (state_q)
      ST_FILL: begin
        if (close) begin
          xfer_cnt = cnt_close;
          if (out_free) begin
            xfer = 1'b1;
          end else begin
            state_d = ST_HELD;
            cnt_d   = cnt_close;
          end
        end else if (row_acc) begin
          cnt_d = cnt_inc;
        end
      end
      ST_HELD: begin
        if (win_acc) begin
          xfer    = 1'b1;
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase

    // Stale slices from earlier, longer windows must read as zero.
    for (int unsigned k = 0; k < maxFilterY; k++) begin
      if (CNT_W'(k) >= xfer_cnt) begin
        win_masked[k*rowWidth +: rowWidth] = '0;
      end
    end

    if (xfer) begin
      win_d       = win_masked;
      win_valid_d = 1'b1;
      rows_d      = 4'(xfer_cnt);
      cnt_d       = '0;
    end

    row_ready_d = (state_d == ST_FILL);
  end

  // State and datapath registers; clear_i behaves exactly like rst.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      state_q     <= ST_FILL;
      cnt_q       <= '0;
      fill_q      <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      rows_q      <= '0;
      row_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_q      <= fill_wr;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      rows_q      <= rows_d;
      row_ready_q <= row_ready_d;
    end
  end

  assign bus.row_ready_o    = row_ready_q;
  assign bus.window_valid_o = win_valid_q;
  assign bus.window_o       = win_q;
  assign bus.window_rows_o  = rows_q;

`ifdef QRACC_WINDOW_ERR_CHECK_EN
  logic [3:0] fsy_eff;
  logic       err_q, err_d;

  // Sticky framing error: wrong row count on a closing row, or overflow.
  always_comb begin
    fsy_eff = (filter_size_y_i == 4'd0) ? 4'(maxFilterY) : filter_size_y_i;
    err_d   = err_q;
    if (close && (overflow || (4'(cnt_close) != fsy_eff))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err_o = err_q;
`else
  logic unused_fsy;
  assign unused_fsy = ^filter_size_y_i;
  assign bus.err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_qracc_window_assembler.sv
// tb_qracc_window_assembler: directed scenarios with literal expectations plus
// randomized traffic, all checked against a window-level reference model.
module tb_qracc_window_assembler;

  localparam int unsigned RW = 128;
  localparam int unsigned MY = 8;
  localparam int unsigned WW = RW * MY;

`ifdef QRACC_WINDOW_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [WW-1:0] data;
    int            rows;
  } win_t;

  logic       clk;
  logic       rst;
  logic       clear_i;
  logic [3:0] fsy;

  int checks = 0;
  int errors = 0;

  qracc_window_assembler_if #(.rowWidth(RW), .maxFilterY(MY)) bus ();

  qracc_window_assembler #(.rowWidth(RW), .maxFilterY(MY)) dut (
    .clk             (clk),
    .rst             (rst),
    .clear_i         (clear_i),
    .filter_size_y_i (fsy),
    .bus             (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_win(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int k = 0; k < int'(MY); k++) begin
        if (act[k*RW +: RW] !== exp[k*RW +: RW]) begin
          $display("FAIL %s: slice %0d got %h expected %h (t=%0t)", name, k,
                   act[k*RW +: RW], exp[k*RW +: RW], $time);
          break;
        end
      end
    end
  endtask

  function automatic logic [RW-1:0] mkrow(input int unsigned n);
    logic [31:0] w;
    w = 32'hC0DE_0000 + n;
    return {4{w}};
  endfunction

  // Reference model: windows as row lists, one presented window and at most
  // one completed window waiting behind it.
  win_t          out_q[$];
  win_t          pend_q[$];
  logic [RW-1:0] cur[$];
  bit            m_err;
  bit            m_zero;
  win_t          w;
  bit            m_ready, m_wacc, m_racc, m_ovf;
  int            fy;

  always @(posedge clk) begin
    if (rst || clear_i) begin
      out_q.delete();
      pend_q.delete();
      cur.delete();
      m_err  = 1'b0;
      m_zero = 1'b1;
    end else begin
      m_ready = (pend_q.size() == 0);
      m_wacc  = (out_q.size() != 0) && bus.window_ready_i;
      m_racc  = bus.row_valid_i && m_ready;
      if (m_wacc) begin
        void'(out_q.pop_front());
        if (pend_q.size() != 0) out_q.push_back(pend_q.pop_front());
      end
      if (m_racc) begin
        m_ovf = (cur.size() == int'(MY));
        if (!m_ovf) cur.push_back(bus.row_data_i);
        if (m_ovf || bus.row_last_i) begin
          w.data = '0;
          foreach (cur[k]) w.data[k*RW +: RW] = cur[k];
          w.rows = cur.size();
          fy = (fsy == 4'd0) ? int'(MY) : int'(fsy);
          if (m_ovf || (w.rows != fy)) m_err = 1'b1;
          cur.delete();
          if (out_q.size() == 0) out_q.push_back(w);
          else pend_q.push_back(w);
          m_zero = 1'b0;
        end
      end
    end
    #1;
    chk("mon_row_ready", 64'(bus.row_ready_o), 64'(pend_q.size() == 0));
    chk("mon_window_valid", 64'(bus.window_valid_o), 64'(out_q.size() != 0));
    chk("mon_err", 64'(bus.err_o), 64'(ERR_EN && m_err));
    if (out_q.size() != 0) begin
      chk("mon_rows", 64'(bus.window_rows_o), 64'(out_q[0].rows));
      chk_win("mon_window", bus.window_o, out_q[0].data);
    end else if (m_zero) begin
      chk("mon_rows_zero", 64'(bus.window_rows_o), 64'd0);
      chk_win("mon_window_zero", bus.window_o, '0);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send(input logic [RW-1:0] d, input bit last);
    bus.row_valid_i = 1'b1;
    bus.row_data_i  = d;
    bus.row_last_i  = last;
    step();
  endtask

  task automatic idle();
    bus.row_valid_i = 1'b0;
    bus.row_last_i  = 1'b0;
  endtask

  task automatic do_clear();
    idle();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
  endtask

  logic [WW-1:0] exp_w;

  initial begin
    rst                = 1'b1;
    clear_i            = 1'b0;
    fsy                = 4'd3;
    bus.row_valid_i    = 1'b0;
    bus.row_data_i     = '0;
    bus.row_last_i     = 1'b0;
    bus.window_ready_i = 1'b0;
    step();
    step();
    chk("reset_row_ready", 64'(bus.row_ready_o), 64'd1);
    chk("reset_window_valid", 64'(bus.window_valid_o), 64'd0);
    chk("reset_err", 64'(bus.err_o), 64'd0);
    rst = 1'b0;

    // Three-row window, consumer ready.
    fsy = 4'd3;
    bus.window_ready_i = 1'b1;
    send(mkrow(1), 1'b0);
    send(mkrow(2), 1'b0);
    chk("s1_not_yet_valid", 64'(bus.window_valid_o), 64'd0);
    send(mkrow(3), 1'b1);
    chk("s1_latency_valid", 64'(bus.window_valid_o), 64'd1);
    chk("s1_rows", 64'(bus.window_rows_o), 64'd3);
    chk_win("s1_window", bus.window_o, {{(WW-3*RW){1'b0}}, mkrow(3), mkrow(2), mkrow(1)});
    idle();
    step();
    chk("s1_consumed", 64'(bus.window_valid_o), 64'd0);

    // Consumer stalled while a second window completes.
    bus.window_ready_i = 1'b0;
    send(mkrow(4), 1'b0);
    send(mkrow(5), 1'b0);
    send(mkrow(6), 1'b1);
    chk("s2_w1_valid", 64'(bus.window_valid_o), 64'd1);
    chk("s2_fill_ready", 64'(bus.row_ready_o), 64'd1);
    send(mkrow(7), 1'b0);
    send(mkrow(8), 1'b0);
    send(mkrow(9), 1'b1);
    chk("s2_held_ready", 64'(bus.row_ready_o), 64'd0);
    idle();
    step();
    step();
    chk("s2_stall_valid", 64'(bus.window_valid_o), 64'd1);
    chk_win("s2_stall_window", bus.window_o, {{(WW-3*RW){1'b0}}, mkrow(6), mkrow(5), mkrow(4)});
    bus.window_ready_i = 1'b1;
    step();
    chk("s2_w2_valid", 64'(bus.window_valid_o), 64'd1);
    chk("s2_w2_ready", 64'(bus.row_ready_o), 64'd1);
    chk_win("s2_w2_window", bus.window_o, {{(WW-3*RW){1'b0}}, mkrow(9), mkrow(8), mkrow(7)});
    step();
    chk("s2_drained", 64'(bus.window_valid_o), 64'd0);

    // Short window: last on the second row.
    do_clear();
    fsy = 4'd3;
    send(mkrow(10), 1'b0);
    send(mkrow(11), 1'b1);
    chk("s3_rows", 64'(bus.window_rows_o), 64'd2);
    chk_win("s3_window", bus.window_o, {{(WW-2*RW){1'b0}}, mkrow(11), mkrow(10)});
    chk("s3_err", 64'(bus.err_o), 64'(ERR_EN));
    idle();
    step();

    // Nine rows without last: ninth row overflows and is discarded.
    do_clear();
    fsy = 4'd8;
    for (int i = 0; i < 8; i++) send(mkrow(32'h40 + i), 1'b0);
    chk("s4_open_after_8", 64'(bus.window_valid_o), 64'd0);
    send(mkrow(32'h48), 1'b0);
    chk("s4_valid", 64'(bus.window_valid_o), 64'd1);
    chk("s4_rows", 64'(bus.window_rows_o), 64'd8);
    exp_w = '0;
    for (int i = 0; i < 8; i++) exp_w[i*RW +: RW] = mkrow(32'h40 + i);
    chk_win("s4_window", bus.window_o, exp_w);
    chk("s4_err", 64'(bus.err_o), 64'(ERR_EN));
    idle();
    step();

    // filter_size_y = 0 means a full eight-row window with no error.
    do_clear();
    fsy = 4'd0;
    for (int i = 0; i < 8; i++) send(mkrow(32'h50 + i), i == 7);
    chk("s4b_rows", 64'(bus.window_rows_o), 64'd8);
    chk("s4b_err", 64'(bus.err_o), 64'd0);
    idle();
    step();

    // Clear while a window is held.
    do_clear();
    fsy = 4'd3;
    bus.window_ready_i = 1'b0;
    send(mkrow(20), 1'b0);
    send(mkrow(21), 1'b0);
    send(mkrow(22), 1'b1);
    send(mkrow(23), 1'b0);
    send(mkrow(24), 1'b1);
    chk("s5_held", 64'(bus.row_ready_o), 64'd0);
    chk("s5_err_before", 64'(bus.err_o), 64'(ERR_EN));
    do_clear();
    chk("s5_valid_cleared", 64'(bus.window_valid_o), 64'd0);
    chk("s5_ready_cleared", 64'(bus.row_ready_o), 64'd1);
    chk("s5_err_cleared", 64'(bus.err_o), 64'd0);
    chk("s5_rows_cleared", 64'(bus.window_rows_o), 64'd0);
    bus.window_ready_i = 1'b1;
    send(mkrow(25), 1'b0);
    send(mkrow(26), 1'b0);
    send(mkrow(27), 1'b1);
    chk("s5_fresh_valid", 64'(bus.window_valid_o), 64'd1);
    chk_win("s5_fresh_window", bus.window_o, {{(WW-3*RW){1'b0}}, mkrow(27), mkrow(26), mkrow(25)});
    idle();
    step();

    // One-row windows back to back.
    fsy = 4'd1;
    for (int i = 0; i < 6; i++) begin
      send(mkrow(32'h60 + i), 1'b1);
      chk("s6_valid", 64'(bus.window_valid_o), 64'd1);
      chk("s6_rows", 64'(bus.window_rows_o), 64'd1);
      chk_win("s6_window", bus.window_o, {{(WW-RW){1'b0}}, mkrow(32'h60 + i)});
      chk("s6_err", 64'(bus.err_o), 64'd0);
    end
    idle();
    step();
    chk("s6_drained", 64'(bus.window_valid_o), 64'd0);

    // Randomized traffic, checked by the model every cycle.
    do_clear();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 250 == 0) fsy = 4'($urandom_range(0, 8));
      clear_i            = ($urandom_range(0, 299) == 0);
      bus.row_valid_i    = ($urandom_range(0, 3) != 0);
      bus.row_last_i     = ($urandom_range(0, 3) == 0);
      bus.row_data_i     = {$urandom, $urandom, $urandom, $urandom};
      bus.window_ready_i = ($urandom_range(0, 2) != 0);
      step();
    end
    clear_i = 1'b0;
    idle();
    bus.window_ready_i = 1'b1;
    step();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qracc_window_assembler.md
QRACC_WINDOW_ASSEMBLER -- requirements
Module: qracc_window_assembler

Interface
REQ-001 SHALL have parameter rowWidth, default 128, meaning bits per activation-buffer row.
REQ-002 SHALL have parameter maxFilterY, default 8, meaning the maximum rows per window.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port clear_i, input, 1 bit: synchronous soft clear, driven from csr_main_clear.
REQ-006 SHALL have port filter_size_y_i, input, 4 bits: expected rows per window, taken from cfg.
REQ-007 SHALL have port row_valid_i, input, 1 bit: an activation row is offered.
REQ-008 SHALL have port row_ready_o, output, 1 bit: the assembler accepts the offered row.
REQ-009 SHALL have port row_data_i, input, rowWidth bits: the activation row.
REQ-010 SHALL have port row_last_i, input, 1 bit: the offered row closes the current window.
REQ-011 SHALL have port window_valid_o, output, 1 bit: a complete window is presented.
REQ-012 SHALL have port window_ready_i, input, 1 bit: consumer (qracc_ready) accepts the window.
REQ-013 SHALL have port window_o, output, rowWidth*maxFilterY bits: the assembled window.
REQ-014 SHALL have port window_rows_o, output, 4 bits: number of valid rows in window_o.
REQ-015 SHALL have port err_o, output, 1 bit: sticky framing error.

Function
REQ-016 SHALL accept a row only when row_valid_i && row_ready_o, and a window only when window_valid_o && window_ready_i.
REQ-017 SHALL hold two banks: a fill bank and an output bank.
REQ-018 SHALL write the k-th accepted row of a window into fill-bank slice [k*rowWidth +: rowWidth], with k starting at 0.
REQ-019 SHALL have fill state machine states FILL and HELD.
REQ-020 SHALL, in FILL, assert row_ready_o = 1.
REQ-021 SHALL, on an accepted row with row_last_i, move the fill bank to the output bank in the same edge if the output bank is empty or is being accepted that cycle, then stay in FILL; otherwise it SHALL go to HELD.
REQ-022 SHALL, in HELD, drive row_ready_o = 0, and SHALL transfer and return to FILL on the edge on which the output window is accepted.
REQ-023 SHALL zero all fill-bank slices at k >= row count when transferring, so that unused slices of window_o read 0.
REQ-024 SHALL reset the fill count to 0 after every transfer.
REQ-025 SHALL keep window_o, window_rows_o and window_valid_o stable while window_valid_o && !window_ready_i.
REQ-026 SHALL have latency from the edge accepting the last row to window_valid_o = 1 of exactly 1 cycle when the output bank is free.
REQ-027 SHALL sustain throughput of one window per filter_size_y cycles with window_ready_i held high.
REQ-028 SHALL, on overflow (a row accepted while the count equals maxFilterY), discard that row and treat it as row_last.
REQ-029 SHALL treat filter_size_y_i = 0 as maxFilterY.

Reset
REQ-030 SHALL, on rst or clear_i, drive row_ready_o = 1, window_valid_o = 0, window_o = 0, window_rows_o = 0 and err_o = 0, set the fill count to 0 and the state to FILL.
REQ-031 SHALL give clear_i priority over any simultaneous handshake, and SHALL drop any in-flight window.

Configuration
REQ-032 SHALL, with QRACC_WINDOW_ERR_CHECK_EN defined, set err_o when a row_last row gives count != filter_size_y_i, and also on overflow.
REQ-033 SHALL keep err_o set until rst or clear_i.
REQ-034 SHALL, without QRACC_WINDOW_ERR_CHECK_EN, tie err_o to 0 and omit the comparison logic.
REQ-035 SHALL leave datapath behaviour identical with and without QRACC_WINDOW_ERR_CHECK_EN.

Structure
REQ-036 SHALL place constants QRACC_ROW_WIDTH and QRACC_MAX_FILTER_Y and an enum typedef for the fill states in qracc_pkg.
REQ-037 SHALL be a single module; no sub-module is warranted.

Verification
REQ-038 Bench SHALL cover: filter_size_y = 3, rows A, B, C with last on C, ready high -> window_valid 1 cycle after C, window_o = {0..., C, B, A}, rows = 3.
REQ-039 Bench SHALL cover: window_ready held low while a second 3-row window completes -> row_ready drops after the 2nd window's last row, and both windows are delivered in order once ready rises.
REQ-040 Bench SHALL cover: filter_size_y = 3 with last on the 2nd row -> rows = 2, slices 2..7 zero, and err_o = 1 only when ERR_CHECK_EN is defined.
REQ-041 Bench SHALL cover: 9 rows without last, maxFilterY = 8 -> window closed after the 8th row, the 9th row discarded, and err_o = 1 when enabled.
REQ-042 Bench SHALL cover: clear_i asserted during HELD -> the next cycle shows window_valid = 0, row_ready = 1, err_o = 0, and a fresh window then assembles correctly.
REQ-043 Bench SHALL cover: filter_size_y = 1 with continuous rows and ready high -> window_valid on every cycle, each window carrying exactly one row.
